// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer: issues one ALU op per command and streams the result bytes to the UART TX
module alu_uart_sequencer #(
    parameter int ALU_LATENCY = 1,
    parameter int SEND_FLAGS  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] operando1,
    input  logic [15:0] operando2,
    input  logic [2:0]  ALU_ctrl,
    input  logic        cmd_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic [4:0]  alu_flags,
    output logic [15:0] result_reg,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        busy,
    output logic        done,
    output logic        overrun
);
    typedef enum logic [2:0] {IDLE, EXEC, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI, SEND_FLG, WAIT_FLG} state_t;
    state_t      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  flg_q, flg_d, txd_q, txd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        txs_q, txs_d, seen_q, seen_d, ovr_q, ovr_d;
    logic        is_send, is_wait;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign result_reg = res_q;
    assign tx_data    = txd_q;
    assign tx_start   = txs_q;
    assign overrun    = ovr_q;
    assign busy       = state_q != IDLE;
    assign is_send    = state_q == SEND_LO || state_q == SEND_HI || state_q == SEND_FLG;
    assign is_wait    = state_q == WAIT_LO || state_q == WAIT_HI || state_q == WAIT_FLG;
    // state and datapath registers; reset abandons any partial response
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            txd_q   <= '0;
            cnt_q   <= '0;
            txs_q   <= 1'b0;
            seen_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            txd_q   <= txd_d;
            cnt_q   <= cnt_d;
            txs_q   <= txs_d;
            seen_q  <= seen_d;
            ovr_q   <= ovr_d;
        end
    end
    // next-state: accept, wait out ALU latency, then send each byte and wait for TX busy to cycle
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        flg_d   = flg_q;
        txd_d   = txd_q;
        cnt_d   = cnt_q;
        txs_d   = 1'b0;
        seen_d  = seen_q;
        done    = 1'b0;
        ovr_d   = ovr_q | (cmd_ready && state_q != IDLE);
        if (state_q == IDLE && cmd_ready) begin
            a_d     = operando1;
            b_d     = operando2;
            op_d    = ALU_ctrl;
            cnt_d   = 4'(ALU_LATENCY);
            state_d = EXEC;
        end
        if (state_q == EXEC) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                res_d   = alu_result;
                flg_d   = {3'b000, alu_flags};
                state_d = SEND_LO;
            end
        end
        if (is_send && !tx_busy) begin
            txs_d   = 1'b1;
            txd_d   = state_q == SEND_LO ? res_q[7:0] : state_q == SEND_HI ? res_q[15:8] : flg_q;
            state_d = state_q == SEND_LO ? WAIT_LO : state_q == SEND_HI ? WAIT_HI : WAIT_FLG;
        end
        if (is_wait) begin
            seen_d = seen_q | tx_busy;
            if (seen_q && !tx_busy) begin
                seen_d  = 1'b0;
                done    = state_q == WAIT_FLG || (state_q == WAIT_HI && SEND_FLAGS == 0);
                state_d = state_q == WAIT_LO ? SEND_HI : (state_q == WAIT_HI && SEND_FLAGS != 0) ? SEND_FLG : IDLE;
            end
        end
    end
endmodule

// File: tb/tb_alu_uart_sequencer.sv
// tb_alu_uart_sequencer: directed checks of two sequencer configurations against a simple TX/ALU model
module tb_alu_uart_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] op1 = '0, op2 = '0;
    logic [2:0]  ctl = '0;
    logic        cmd0 = 1'b0, cmd1 = 1'b0, force0 = 1'b0;
    logic [4:0]  flg0 = '0;
    logic [15:0] res1 = '0;
    logic [15:0] alu_a0, alu_b0, result_reg0, alu_a1, alu_b1, result_reg1;
    logic [2:0]  alu_op0, alu_op1;
    logic [7:0]  tx_data0, tx_data1;
    logic        tx_start0, busy0, done0, overrun0, tx_start1, busy1, done1, overrun1;
    logic [15:0] alu_res0;
    logic [3:0]  cnt0 = '0, cnt1 = '0;
    logic [7:0]  q0[$], q1[$];
    int          n_start0 = 0, n_start1 = 0, n_done0 = 0, n_done1 = 0;
    int          n_tests = 0, n_fail = 0;
    assign alu_res0 = alu_a0 + alu_b0;

    always #5 clock = ~clock;

    alu_uart_sequencer #(.ALU_LATENCY(1), .SEND_FLAGS(1)) u0 (
        .clock(clock), .reset(reset), .operando1(op1), .operando2(op2), .ALU_ctrl(ctl), .cmd_ready(cmd0),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_op(alu_op0), .alu_result(alu_res0), .alu_flags(flg0),
        .result_reg(result_reg0), .tx_data(tx_data0), .tx_start(tx_start0), .tx_busy((cnt0 != 0) | force0),
        .busy(busy0), .done(done0), .overrun(overrun0));

    alu_uart_sequencer #(.ALU_LATENCY(4), .SEND_FLAGS(0)) u1 (
        .clock(clock), .reset(reset), .operando1(op1), .operando2(op2), .ALU_ctrl(ctl), .cmd_ready(cmd1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_result(res1), .alu_flags(5'h00),
        .result_reg(result_reg1), .tx_data(tx_data1), .tx_start(tx_start1), .tx_busy(cnt1 != 0),
        .busy(busy1), .done(done1), .overrun(overrun1));

    // TX model: busy for 10 cycles starting the cycle after each tx_start; records bytes and pulses
    always @(posedge clock) begin
        if (reset) cnt0 <= '0;
        else if (tx_start0) begin cnt0 <= 4'd10; q0.push_back(tx_data0); end
        else if (cnt0 != 0) cnt0 <= cnt0 - 4'd1;
        if (reset) cnt1 <= '0;
        else if (tx_start1) begin cnt1 <= 4'd10; q1.push_back(tx_data1); end
        else if (cnt1 != 0) cnt1 <= cnt1 - 4'd1;
        if (tx_start0) n_start0 <= n_start0 + 1;
        if (tx_start1) n_start1 <= n_start1 + 1;
        if (done0) n_done0 <= n_done0 + 1;
        if (done1) n_done1 <= n_done1 + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input int which, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        op1 = a; op2 = b; ctl = op;
        if (which == 0) cmd0 = 1'b1; else cmd1 = 1'b1;
        tick();
        cmd0 = 1'b0; cmd1 = 1'b0;
    endtask

    task automatic wait_done(input int which, input string tag);
        int base = which == 0 ? n_done0 : n_done1;
        int k = 0;
        while ((which == 0 ? n_done0 : n_done1) == base && k < 400) begin tick(); k++; end
        check({tag, "_timeout"}, k < 400, 1);
    endtask

    task automatic wait_start0(input int target, input string tag);
        int k = 0;
        while (n_start0 < target && k < 400) begin tick(); k++; end
        check({tag, "_timeout"}, n_start0 >= target, 1);
    endtask

    task automatic expect_bytes(input string tag, input int which, input int base, input int n, input logic [23:0] exp);
        int sz = which == 0 ? q0.size() : q1.size();
        check({tag, "_nbytes"}, sz - base, n);
        for (int i = 0; i < n; i++)
            if (base + i < sz) check({tag, "_byte"}, which == 0 ? q0[base + i] : q1[base + i], exp[8*i +: 8]);
    endtask

    initial begin
        int sb, db, bad;
        tick(); tick();
        check("rst_u0", {alu_a0, alu_b0, alu_op0, result_reg0, tx_data0, tx_start0, busy0, done0, overrun0}, 0);
        check("rst_u1", {alu_a1, alu_b1, alu_op1, result_reg1, tx_data1, tx_start1, busy1, done1, overrun1}, 0);
        reset = 1'b0;
        tick();
        // basic 3-byte response with first-byte latency
        flg0 = 5'h03; sb = q0.size(); db = n_done0;
        issue(0, 16'h1234, 16'h0001, 3'd0);
        check("a_ops", {alu_a0, alu_b0, alu_op0, busy0}, {16'h1234, 16'h0001, 3'd0, 1'b1});
        tick();
        check("a_res_early", {result_reg0, tx_start0}, {16'h1235, 1'b0});
        tick();
        check("a_first_start", {tx_start0, tx_data0}, {1'b1, 8'h35});
        wait_done(0, "a_done");
        check("a_bytes_at_done", q0.size() - sb, 3);
        check("a_busy_fall", busy0, 0);
        repeat (20) tick();
        expect_bytes("a", 0, sb, 3, 24'h031235);
        check("a_starts", n_start0, 3);
        check("a_done_once", n_done0 - db, 1);
        check("a_result", result_reg0, 16'h1235);
        // TX busy held high before the first byte
        flg0 = 5'h1F; sb = q0.size(); force0 = 1'b1; bad = 0;
        issue(0, 16'h00FF, 16'h0F01, 3'd0);
        for (int i = 0; i < 20; i++) begin tick(); if (tx_start0) bad++; end
        check("b_no_start_while_busy", bad, 0);
        force0 = 1'b0;
        tick();
        check("b_start_after_busy", {tx_start0, tx_data0}, {1'b1, 8'h00});
        wait_done(0, "b_done");
        tick();
        expect_bytes("b", 0, sb, 3, 24'h1F1000);
        // second command during WAIT_HI is dropped and flags overrun
        flg0 = 5'h05; sb = n_start0; db = n_done0;
        issue(0, 16'h0102, 16'h0304, 3'd2);
        wait_start0(sb + 2, "c_hi");
        repeat (3) tick();
        issue(0, 16'hAAAA, 16'h1111, 3'd5);
        check("c_overrun", {overrun0, alu_a0, alu_b0, alu_op0}, {1'b1, 16'h0102, 16'h0304, 3'd2});
        wait_done(0, "c_done");
        repeat (50) tick();
        expect_bytes("c", 0, sb, 3, 24'h050406);
        check("c_no_second_resp", {n_start0 - sb, n_done0 - db}, {32'd3, 32'd1});
        check("c_overrun_sticky", overrun0, 1);
        // reset during WAIT_HI abandons the response
        flg0 = 5'h02; sb = n_start0;
        issue(0, 16'h5555, 16'h0001, 3'd0);
        wait_start0(sb + 2, "d_hi");
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("d_rst_outputs", {alu_a0, alu_b0, alu_op0, result_reg0, tx_data0, tx_start0, busy0, done0, overrun0}, 0);
        reset = 1'b0;
        repeat (30) tick();
        check("d_no_more_start", n_start0 - sb, 2);
        sb = q0.size();
        issue(0, 16'h0010, 16'h0020, 3'd0);
        wait_done(0, "d_done");
        tick();
        expect_bytes("d", 0, sb, 3, 24'h020030);
        // SEND_FLAGS=0: two bytes only, busy falls after done
        res1 = 16'h0000; sb = q1.size();
        issue(1, 16'hFFFF, 16'h0001, 3'd0);
        wait_done(1, "e_done");
        check("e_bytes_at_done", q1.size() - sb, 2);
        check("e_busy_fall", busy1, 0);
        repeat (20) tick();
        expect_bytes("e", 1, sb, 2, 24'h000000);
        check("e_starts", n_start1, 2);
        // ALU_LATENCY=4: result taken from the value present in cycle 4
        sb = q1.size(); res1 = 16'hA000;
        issue(1, 16'h0001, 16'h0002, 3'd1);
        for (int c = 1; c <= 6; c++) begin
            if (c == 4) check("f_not_yet", result_reg1, 16'h0000);
            if (c == 5) check("f_capture", result_reg1, 16'hA004);
            res1 = 16'hA000 + 16'(c);
            if (c < 6) tick();
        end
        wait_done(1, "f_done");
        tick();
        expect_bytes("f", 1, sb, 2, 24'h00A004);
        check("f_overrun_clear", overrun1, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
